// File: rtl/golden_nonce_reporter_pkg.sv
// Shared constants, serializer state encoding and frame byte selection for golden_nonce_reporter.
// Build option: NONCE_SYNC_BYTE_EN prefixes every frame with NONCE_SYNC_BYTE.
package golden_nonce_reporter_pkg;

    localparam logic [7:0]  NONCE_SYNC_BYTE = 8'hAA;
    localparam int unsigned UART_FRAME_BITS = 10;

`ifdef NONCE_SYNC_BYTE_EN
    localparam int unsigned FRAME_BYTES = 5;
`else
    localparam int unsigned FRAME_BYTES = 4;
`endif

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    // Byte idx of the frame for a given nonce; bytes go out MSB byte first.
    function automatic logic [7:0] frame_byte(input logic [31:0] nonce, input logic [2:0] idx);
        logic [7:0] b;
`ifdef NONCE_SYNC_BYTE_EN
        case (idx)
            3'd0:    b = NONCE_SYNC_BYTE;
            3'd1:    b = nonce[31:24];
            3'd2:    b = nonce[23:16];
            3'd3:    b = nonce[15:8];
            default: b = nonce[7:0];
        endcase
`else
        case (idx)
            3'd0:    b = nonce[31:24];
            3'd1:    b = nonce[23:16];
            3'd2:    b = nonce[15:8];
            default: b = nonce[7:0];
        endcase
`endif
        return b;
    endfunction

endpackage

// File: rtl/golden_nonce_reporter_if.sv
// Golden-ticket strobe bus from the hashing core into golden_nonce_reporter.
interface golden_nonce_reporter_if;

    logic        golden_valid;
    logic [31:0] golden_nonce;

    modport master (output golden_valid, output golden_nonce);
    modport slave  (input  golden_valid, input  golden_nonce);

endinterface

// File: rtl/golden_nonce_reporter_uart_tx_8n1.sv
// 8N1 UART byte transmitter: owns START/DATA/STOP bit timing; tx is registered and idles high.
module golden_nonce_reporter_uart_tx_8n1
    import golden_nonce_reporter_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       hash_clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam logic [15:0] BitReload = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LastBit   = 3'(UART_FRAME_BITS - 3);

    tx_state_e   state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  data_q, data_d;
    logic        tx_q, tx_d;
    logic        bit_done;

    assign bit_done = (timer_q == 16'd0);
    // A new byte can be taken from idle or at the very end of a stop bit (no inter-byte gap).
    assign byte_ready = (state_q == StIdle) || ((state_q == StStop) && bit_done);
    assign tx = tx_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        case (state_q)
            StIdle: begin
                if (byte_valid) begin
                    state_d = StStart;
                    timer_d = BitReload;
                    data_d  = byte_data;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d   = StData;
                    timer_d   = BitReload;
                    bit_idx_d = 3'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            StData: begin
                if (bit_done) begin
                    timer_d = BitReload;
                    if (bit_idx_q == LastBit) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    if (byte_valid) begin
                        state_d = StStart;
                        timer_d = BitReload;
                        data_d  = byte_data;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the current state, so tx lags the state register by one cycle.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = data_q[bit_idx_q];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            data_q    <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: rtl/golden_nonce_reporter.sv
// Buffers golden nonces in a FIFO and sends each as a multi-byte 8N1 UART frame; drops are counted.
// Build option: NONCE_SYNC_BYTE_EN adds a sync-byte prefix to every frame.
module golden_nonce_reporter
    import golden_nonce_reporter_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT    = 434,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic                          hash_clk,
    input  logic                          reset,
    golden_nonce_reporter_if.slave        nonce_in,
    output logic                          uart_tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [7:0]                    overflow_cnt
);

    localparam int unsigned            Depth    = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] DepthCnt = (FIFO_DEPTH_LOG2 + 1)'(Depth);
    localparam logic [2:0]             LastByte = 3'(FRAME_BYTES - 1);

    logic [31:0]                fifo_mem [Depth];
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]   count_q;
    logic                       fifo_empty;
    logic                       push, pop;

    logic        frame_active_q;
    logic [31:0] nonce_q;
    logic [2:0]  byte_idx_q;
    logic [7:0]  overflow_cnt_q;

    logic       byte_valid, byte_ready;
    logic [7:0] byte_data;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == DepthCnt);
    assign busy         = frame_active_q || !fifo_empty;
    assign overflow_cnt = overflow_cnt_q;

    // A full FIFO still accepts a strobe in the cycle it pops.
    assign push = nonce_in.golden_valid && !reset && (!fifo_full || pop);

    always_comb begin
        pop        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = frame_byte(fifo_mem[rd_ptr_q], 3'd0);
        if (!frame_active_q) begin
            if (!fifo_empty && byte_ready) begin
                pop        = 1'b1;
                byte_valid = 1'b1;
            end
        end else if (byte_idx_q != LastByte) begin
            byte_valid = 1'b1;
            byte_data  = frame_byte(nonce_q, byte_idx_q + 3'd1);
        end
    end

    always_ff @(posedge hash_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= nonce_in.golden_nonce;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            overflow_cnt_q <= 8'd0;
            frame_active_q <= 1'b0;
            nonce_q        <= 32'd0;
            byte_idx_q     <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (nonce_in.golden_valid && !push && (overflow_cnt_q != 8'hFF)) begin
                overflow_cnt_q <= overflow_cnt_q + 8'd1;
            end
            if (pop) begin
                frame_active_q <= 1'b1;
                nonce_q        <= fifo_mem[rd_ptr_q];
                byte_idx_q     <= 3'd0;
            end else if (frame_active_q && byte_ready) begin
                // byte_ready mid-frame means the current byte's stop bit just ended.
                if (byte_idx_q == LastByte) begin
                    frame_active_q <= 1'b0;
                end else begin
                    byte_idx_q <= byte_idx_q + 3'd1;
                end
            end
        end
    end

    golden_nonce_reporter_uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .hash_clk   (hash_clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .tx         (uart_tx)
    );

endmodule
